// File: rtl/expr_sched_pkg.sv
// Shared types and constants for the expression-checker scheduler.
package expr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_SAMPLE = 2'd3
  } state_e;

  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  // One-hot requester vector for a 1-bit requester index.
  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/expr_buf.sv
// Expression character buffer: synchronous write, combinational read.
module expr_buf #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [1<<AW];

  // Store one character per accepted write.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/expr_sched.sv
// Two-requester arbiter and sequencer feeding a free-running expression checker.
module expr_sched
  import expr_sched_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [1:0]  s_valid,
  input  logic [15:0] s_data,
  input  logic [1:0]  s_last,
  output logic [1:0]  s_ready,
  output logic [1:0]  res_valid,
  output logic        res_ok,
  output logic        res_ovf,
  output logic        busy,
  output logic        chk_clr,
  output logic [7:0]  chk_in,
  input  logic        chk_out
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  state_e        state_q;
  logic          g_q;
  logic          ptr_q;
  logic          ovf_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    res_valid_q;
  logic          res_ok_q;
  logic          res_ovf_q;

  logic          grant_d;
  logic          acc;
  logic          full;
  logic [7:0]    acc_data;
  logic [7:0]    rdata;

  assign grant_d  = (&s_valid) ? ptr_q : s_valid[1];
  assign acc      = (state_q == ST_LOAD) & s_valid[g_q];
  assign full     = (cnt_q == FULL);
  assign acc_data = g_q ? s_data[15:8] : s_data[7:0];

  expr_buf #(.AW(AW), .DW(8)) u_buf (
    .clk   (clk),
    .we    (acc & ~full),
    .waddr (cnt_q[AW-1:0]),
    .wdata (acc_data),
    .raddr (idx_q),
    .rdata (rdata)
  );

  // Arbitration, buffer loading, streaming and verdict capture.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      g_q         <= 1'b0;
      ptr_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      res_valid_q <= '0;
      res_ok_q    <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      res_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|s_valid) begin
            g_q     <= grant_d;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (acc) begin
            if (full) ovf_q <= 1'b1;
            else      cnt_q <= cnt_q + 1'b1;
            // An s_last that itself overflows must also skip streaming.
            if (s_last[g_q]) begin
              idx_q   <= '0;
              state_q <= (full | ovf_q) ? ST_SAMPLE : ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if ({1'b0, idx_q} == cnt_q - 1'b1) state_q <= ST_SAMPLE;
          else                               idx_q   <= idx_q + 1'b1;
        end
        ST_SAMPLE: begin
          res_valid_q <= onehot2(g_q);
          res_ok_q    <= chk_out & ~ovf_q;
          res_ovf_q   <= ovf_q;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          ptr_q       <= ~ptr_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    s_ready = (state_q == ST_LOAD) ? onehot2(g_q) : 2'b00;
    busy    = (state_q != ST_IDLE);
    // Overflowed expressions never release the checker from clear.
    chk_clr = (state_q == ST_IDLE) | (state_q == ST_LOAD) |
              ((state_q == ST_SAMPLE) & ovf_q);
    chk_in  = (state_q == ST_STREAM) ? rdata : 8'h00;
  end

  assign res_valid = res_valid_q;
  assign res_ok    = res_ok_q;
  assign res_ovf   = res_ovf_q;

endmodule
